// File: rtl/cnu_msg_gen_if.sv
// Record-in / message-out handshake bundle for the check-node message generator.
// The master drives compressed records and accepts messages; the slave is the generator.
interface cnu_msg_gen_if #(
  parameter int BITS = 8,
  parameter int DEG  = 256,
  parameter int K    = $clog2(DEG)
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [BITS-2:0]        in_min1;
  logic [BITS-2:0]        in_min2;
  logic [K-1:0]           in_idx;
  logic [DEG-1:0]         in_sign;
  logic [K:0]             in_deg;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [BITS-1:0] out_msg;
  logic [K-1:0]           out_edge;
  logic                   out_last;

  modport master (
    output in_valid, in_min1, in_min2, in_idx, in_sign, in_deg, out_ready,
    input  in_ready, out_valid, out_msg, out_edge, out_last
  );

  modport slave (
    input  in_valid, in_min1, in_min2, in_idx, in_sign, in_deg, out_ready,
    output in_ready, out_valid, out_msg, out_edge, out_last
  );
endinterface

// File: rtl/cnu_msg_gen.sv
// Expands one compressed min-sum check-node record into one signed message per edge.
// Define CNU_OFFSET_EN to build the offset min-sum variant (magnitudes reduced by OFFSET, floored at 0).
module cnu_msg_gen #(
  parameter int BITS   = 8,
  parameter int DEG    = 256,
  parameter int K      = $clog2(DEG),
  parameter int OFFSET = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  cnu_msg_gen_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

`ifdef CNU_OFFSET_EN
  localparam bit OFF_ON = 1'b1;
`else
  localparam bit OFF_ON = 1'b0;
`endif
  localparam logic [BITS-2:0] OFF_M = OFF_ON ? (BITS-1)'(OFFSET) : '0;

  state_t                 state, state_nxt;
  logic [K-1:0]           e;
  logic [K-1:0]           d_last;
  logic [K-1:0]           idx_r;
  logic [BITS-2:0]        mag1_r, mag2_r;
  logic [DEG-1:0]         sign_r;
  logic                   s_r;

  logic [K:0]             deg_eff;
  logic [DEG-1:0]         keep;
  logic [DEG-1:0]         sign_kept;
  logic                   accept;
  logic                   step;
  logic                   last;
  logic [BITS-2:0]        mag;
  logic signed [BITS-1:0] mag_s;
  logic signed [BITS-1:0] msg;

  function automatic logic [BITS-2:0] shave(input logic [BITS-2:0] m);
    return (m > OFF_M) ? m - OFF_M : '0;
  endfunction

  // Degree 0 or anything above DEG means a full-degree record.
  always_comb begin
    deg_eff = (bus.in_deg == '0 || bus.in_deg > (K+1)'(DEG)) ? (K+1)'(DEG) : bus.in_deg;
    for (int i = 0; i < DEG; i++) keep[i] = (K+1)'(i) < deg_eff;
    sign_kept = bus.in_sign & keep;
  end

  assign accept = bus.in_valid && bus.in_ready;
  assign step   = (state == EMIT) && bus.out_ready;
  assign last   = (e == d_last);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EMIT;
      EMIT: if (step && last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      e <= '0;
    else if (accept) e <= '0;
    else if (step)   e <= e + K'(1);
  end

  // NOTE: the record registers carry no reset; nothing reads them outside EMIT, which is only entered by loading them.
  always_ff @(posedge clk) begin
    if (accept) begin
      mag1_r <= shave(bus.in_min1);
      mag2_r <= shave(bus.in_min2);
      idx_r  <= bus.in_idx;
      sign_r <= sign_kept;
      s_r    <= ^sign_kept;
      d_last <= K'(deg_eff - (K+1)'(1));
    end
  end

  // An idx at or beyond the degree never matches e, so every edge then takes min1.
  always_comb begin
    mag   = (e == idx_r) ? mag2_r : mag1_r;
    mag_s = {1'b0, mag};
    msg   = (s_r ^ sign_r[e]) ? -mag_s : mag_s;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_msg   = '0;
    bus.out_edge  = '0;
    bus.out_last  = 1'b0;
    if (state == EMIT) begin
      bus.out_valid = 1'b1;
      bus.out_msg   = msg;
      bus.out_edge  = e;
      bus.out_last  = last;
      bus.in_ready  = rst_n && last && bus.out_ready;
    end else begin
      bus.in_ready  = rst_n;
    end
  end

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Directed scoreboard bench for cnu_msg_gen at BITS=8, DEG=4; follows CNU_OFFSET_EN when defined.
module tb_cnu_msg_gen;
  localparam int BITS   = 8;
  localparam int DEG    = 4;
  localparam int K      = 2;
  localparam int OFFSET = 1;

  typedef struct {
    logic signed [BITS-1:0] msg;
    logic [K-1:0]           edge_n;
    logic                   last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnu_msg_gen_if #(.BITS(BITS), .DEG(DEG), .K(K)) bus ();

  cnu_msg_gen #(.BITS(BITS), .DEG(DEG), .K(K), .OFFSET(OFFSET)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t sb[$];
  int    beat_cyc[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;

  logic                   prev_stall = 1'b0;
  logic signed [BITS-1:0] prev_msg;
  logic [K-1:0]           prev_edge;
  logic                   prev_last;
  beat_t                  mb;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tb_mag(input int m);
`ifdef CNU_OFFSET_EN
    return (m > OFFSET) ? m - OFFSET : 0;
`else
    return m;
`endif
  endfunction

  task automatic push_exp(input int msg, input int edge_n, input bit last);
    beat_t b;
    b.msg    = BITS'(msg);
    b.edge_n = K'(edge_n);
    b.last   = last;
    sb.push_back(b);
  endtask

  task automatic push_model(input int m1, input int m2, input int idx, input logic [3:0] sg, input int dg);
    int   d;
    logic s;
    d = (dg == 0 || dg > DEG) ? DEG : dg;
    s = 1'b0;
    for (int i = 0; i < d; i++) s ^= sg[i];
    for (int k = 0; k < d; k++) begin
      int m;
      m = (k == idx) ? tb_mag(m2) : tb_mag(m1);
      push_exp((s ^ sg[k]) ? -m : m, k, k == d - 1);
    end
  endtask

  // Presents a record and waits for acceptance; expectations are queued at the accepting edge.
  task automatic send_record(input int m1, input int m2, input int idx, input logic [3:0] sg,
                             input int dg, input bit use_model = 1'b1);
    bit accepted;
    accepted = 1'b0;
    bus.in_min1  = 7'(m1);
    bus.in_min2  = 7'(m2);
    bus.in_idx   = K'(idx);
    bus.in_sign  = sg;
    bus.in_deg   = 3'(dg);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        if (use_model) push_model(m1, m2, idx, sg, dg);
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check("accept_timeout", 32'(accepted), 1);
    bus.in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic drain(input int mode);
    for (int n = 0; n < 300 && sb.size() > 0; n++) begin
      case (mode)
        1:       bus.out_ready = (n % 3 == 0);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
      @(posedge clk);
      #1;
    end
    check("drain_left", sb.size(), 0);
    sb.delete();
    bus.out_ready = 1'b1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n && bus.out_valid) begin
      if (prev_stall) begin
        check("stall_msg",  bus.out_msg,  prev_msg);
        check("stall_edge", bus.out_edge, prev_edge);
        check("stall_last", bus.out_last, prev_last);
      end
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(bus.out_valid), 0);
        end else begin
          mb = sb.pop_front();
          check("msg",  bus.out_msg,  mb.msg);
          check("edge", bus.out_edge, mb.edge_n);
          check("last", bus.out_last, mb.last);
          beat_cyc.push_back(cyc);
        end
      end
    end
    prev_stall = rst_n && bus.out_valid && !bus.out_ready;
    prev_msg   = bus.out_msg;
    prev_edge  = bus.out_edge;
    prev_last  = bus.out_last;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_min1   = '0;
    bus.in_min2   = '0;
    bus.in_idx    = '0;
    bus.in_sign   = '0;
    bus.in_deg    = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_msg",   bus.out_msg,   0);
    check("rst_out_edge",  bus.out_edge,  0);
    check("rst_out_last",  bus.out_last,  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready",  bus.in_ready,  1);
    check("idle_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Basic expansion: S=1, so +3, -3, -7, -3
`ifdef CNU_OFFSET_EN
    push_exp(2, 0, 0); push_exp(-2, 1, 0); push_exp(-6, 2, 0); push_exp(-2, 3, 1);
`else
    push_exp(3, 0, 0); push_exp(-3, 1, 0); push_exp(-7, 2, 0); push_exp(-3, 3, 1);
`endif
    send_record(3, 7, 2, 4'b0001, 4, 1'b0);
    @(negedge clk);
    check("first_beat_latency", bus.out_valid, 1);
    @(posedge clk);
    #1;
    drain(0);

    // Backpressure: same record, exactly four transfers in edge order
    beat_cyc.delete();
    send_record(3, 7, 2, 4'b0001, 4);
    drain(1);
    check("bp_transfers", beat_cyc.size(), 4);

    // Back-to-back records with no bubble
    beat_cyc.delete();
    send_record(3, 7, 2, 4'b0001, 4);
    send_record(9, 12, 0, 4'b1010, 4);
    drain(0);
    check("b2b_transfers", beat_cyc.size(), 8);
    if (beat_cyc.size() == 8) begin
      check("b2b_gap",  beat_cyc[4] - beat_cyc[3], 1);
      check("b2b_span", beat_cyc[7] - beat_cyc[0], 7);
    end

    // Short degree with idx out of range: three beats of +min1
    beat_cyc.delete();
    send_record(5, 9, 3, 4'b1000, 3);
    drain(0);
    check("short_transfers", beat_cyc.size(), 3);

    // Degree 0 and degree above DEG both mean full degree
    send_record(10, 20, 0, 4'b1111, 0);
    drain(0);
    send_record(10, 20, 1, 4'b0011, 6);
    drain(0);

    // Offset corner: min1=1 vanishes under offset, min2=5 becomes 4
    send_record(1, 5, 2, 4'b0110, 4);
    drain(0);

    // Random records under random backpressure
    for (int r = 0; r < 6; r++) begin
      send_record($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 3),
                  4'($urandom_range(0, 15)), $urandom_range(0, 7));
      drain(2);
    end

    // Mid-record reset after two beats
    bus.out_ready = 1'b1;
    send_record(3, 7, 2, 4'b0001, 4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_rst_pending", sb.size(), 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready2", bus.in_ready,  0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    for (int n = 0; n < 6; n++) begin
      check("post_rst_no_stale", bus.out_valid, 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
